// File: rtl/cnn_layer2_pkg.sv
// Shared definitions for the CNN layer-2 parameter loader: FSM states,
// memory selectors, default word counts and memory address widths.
package cnn_layer2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W1,
        LOAD_W2,
        LOAD_B1,
        LOAD_B2,
        VERIFY,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        MEM_W1,
        MEM_W2,
        MEM_B1,
        MEM_B2
    } mem_t;

    localparam int DEF_N_W1 = 150;
    localparam int DEF_N_W2 = 150;
    localparam int DEF_N_B1 = 6;
    localparam int DEF_N_B2 = 4;

    localparam int AW_W1 = 8;
    localparam int AW_W2 = 8;
    localparam int AW_B1 = 3;
    localparam int AW_B2 = 2;

endpackage

// File: rtl/cnn_param_checksum.sv
// Running modular sum of parameter words, widened by 9 bits so that up to
// 512 full-scale words accumulate without wrapping.
module cnn_param_checksum #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          acc_en,
    input  logic [DW-1:0] data,
    output logic [DW+8:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (acc_en) begin
            sum <= sum + {9'd0, data};
        end
    end

endmodule

// File: rtl/cnn_layer2_param_loader.sv
// Streams layer-2 weights/biases into four parameter memories, then optionally
// reads them back and compares read and written checksums.
module cnn_layer2_param_loader
    import cnn_layer2_pkg::*;
#(
    parameter int DW   = 24,
    parameter int N_W1 = DEF_N_W1,
    parameter int N_W2 = DEF_N_W2,
    parameter int N_B1 = DEF_N_B1,
    parameter int N_B2 = DEF_N_B2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             SKIP_VERIFY,
    input  logic             PARAM_VALID,
    input  logic [DW-1:0]    PARAM_DATA,
    output logic             PARAM_READY,
    output logic             CONV_W1_WEN,
    output logic             CONV_W1_REN,
    output logic [AW_W1-1:0] CONV_W1_ADDR,
    output logic [DW-1:0]    CONV_W1_WDATA,
    input  logic [DW-1:0]    CONV_W1_RDATA,
    output logic             CONV_W2_WEN,
    output logic             CONV_W2_REN,
    output logic [AW_W2-1:0] CONV_W2_ADDR,
    output logic [DW-1:0]    CONV_W2_WDATA,
    input  logic [DW-1:0]    CONV_W2_RDATA,
    output logic             CONV_B1_WEN,
    output logic             CONV_B1_REN,
    output logic [AW_B1-1:0] CONV_B1_ADDR,
    output logic [DW-1:0]    CONV_B1_WDATA,
    input  logic [DW-1:0]    CONV_B1_RDATA,
    output logic             CONV_B2_WEN,
    output logic             CONV_B2_REN,
    output logic [AW_B2-1:0] CONV_B2_ADDR,
    output logic [DW-1:0]    CONV_B2_WDATA,
    input  logic [DW-1:0]    CONV_B2_RDATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    state_t        state, state_nxt;
    mem_t          vsel, load_mem, cur_mem;
    logic [7:0]    cnt, cur_last;
    logic          skip, issue_done, last_ren, last_rv, cmp_pend;
    logic [3:0]    wen_q, ren_q, rv_q;
    logic          load_state, hs, at_last, start_ok, rd_issue;
    logic [DW-1:0] rdata_sel;
    logic [DW+8:0] wsum, rsum;

    function automatic logic [7:0] last_of(input mem_t m);
        case (m)
            MEM_W1:  return 8'(N_W1 - 1);
            MEM_W2:  return 8'(N_W2 - 1);
            MEM_B1:  return 8'(N_B1 - 1);
            default: return 8'(N_B2 - 1);
        endcase
    endfunction

    always_comb begin
        load_mem = MEM_W1;
        case (state)
            LOAD_W2: load_mem = MEM_W2;
            LOAD_B1: load_mem = MEM_B1;
            LOAD_B2: load_mem = MEM_B2;
            default: load_mem = MEM_W1;
        endcase
    end

    assign load_state  = (state == LOAD_W1) || (state == LOAD_W2) ||
                         (state == LOAD_B1) || (state == LOAD_B2);
    assign PARAM_READY = load_state;
    assign hs          = PARAM_VALID & load_state;
    assign cur_mem     = (state == VERIFY) ? vsel : load_mem;
    assign cur_last    = last_of(cur_mem);
    assign at_last     = (cnt == cur_last);
    assign start_ok    = (state == IDLE) && START && !ABORT;
    assign rd_issue    = (state == VERIFY) && !issue_done && !ABORT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        BUSY      = (state != IDLE);
        DONE      = 1'b0;
        case (state)
            IDLE:    if (START) state_nxt = LOAD_W1;
            LOAD_W1: if (hs && at_last) state_nxt = LOAD_W2;
            LOAD_W2: if (hs && at_last) state_nxt = LOAD_B1;
            LOAD_B1: if (hs && at_last) state_nxt = LOAD_B2;
            LOAD_B2: if (hs && at_last) state_nxt = skip ? FINISH : VERIFY;
            VERIFY:  if (cmp_pend) state_nxt = FINISH;
            FINISH: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (ABORT) state_nxt = IDLE;
    end

    // Read data returns one cycle after REN; the last word's accumulation lands
    // one cycle later still, so the compare waits on a three-stage marker chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt           <= '0;
            vsel          <= MEM_W1;
            skip          <= 1'b0;
            issue_done    <= 1'b0;
            last_ren      <= 1'b0;
            last_rv       <= 1'b0;
            cmp_pend      <= 1'b0;
            wen_q         <= '0;
            ren_q         <= '0;
            rv_q          <= '0;
            ERR           <= 1'b0;
            CONV_W1_ADDR  <= '0;
            CONV_W2_ADDR  <= '0;
            CONV_B1_ADDR  <= '0;
            CONV_B2_ADDR  <= '0;
            CONV_W1_WDATA <= '0;
            CONV_W2_WDATA <= '0;
            CONV_B1_WDATA <= '0;
            CONV_B2_WDATA <= '0;
        end else begin
            wen_q    <= '0;
            ren_q    <= '0;
            rv_q     <= ren_q;
            last_ren <= 1'b0;
            last_rv  <= last_ren;
            cmp_pend <= last_rv;
            if (ABORT) begin
                cnt        <= '0;
                issue_done <= 1'b0;
                last_rv    <= 1'b0;
                cmp_pend   <= 1'b0;
            end else if (start_ok) begin
                cnt        <= '0;
                skip       <= SKIP_VERIFY;
                vsel       <= MEM_W1;
                issue_done <= 1'b0;
                ERR        <= 1'b0;
            end else if (hs) begin
                wen_q[load_mem] <= 1'b1;
                case (load_mem)
                    MEM_W1: begin CONV_W1_ADDR <= cnt;      CONV_W1_WDATA <= PARAM_DATA; end
                    MEM_W2: begin CONV_W2_ADDR <= cnt;      CONV_W2_WDATA <= PARAM_DATA; end
                    MEM_B1: begin CONV_B1_ADDR <= cnt[2:0]; CONV_B1_WDATA <= PARAM_DATA; end
                    default: begin CONV_B2_ADDR <= cnt[1:0]; CONV_B2_WDATA <= PARAM_DATA; end
                endcase
                cnt <= at_last ? 8'd0 : cnt + 8'd1;
            end else if (rd_issue) begin
                ren_q[vsel] <= 1'b1;
                case (vsel)
                    MEM_W1:  CONV_W1_ADDR <= cnt;
                    MEM_W2:  CONV_W2_ADDR <= cnt;
                    MEM_B1:  CONV_B1_ADDR <= cnt[2:0];
                    default: CONV_B2_ADDR <= cnt[1:0];
                endcase
                if (at_last) begin
                    cnt <= 8'd0;
                    if (vsel == MEM_B2) begin
                        issue_done <= 1'b1;
                        last_ren   <= 1'b1;
                    end else begin
                        vsel <= mem_t'(vsel + 2'd1);
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
            if (cmp_pend && !ABORT) ERR <= (rsum != wsum);
        end
    end

    always_comb begin
        rdata_sel = '0;
        if (rv_q[0])      rdata_sel = CONV_W1_RDATA;
        else if (rv_q[1]) rdata_sel = CONV_W2_RDATA;
        else if (rv_q[2]) rdata_sel = CONV_B1_RDATA;
        else if (rv_q[3]) rdata_sel = CONV_B2_RDATA;
    end

    assign CONV_W1_WEN = wen_q[0];
    assign CONV_W2_WEN = wen_q[1];
    assign CONV_B1_WEN = wen_q[2];
    assign CONV_B2_WEN = wen_q[3];
    assign CONV_W1_REN = ren_q[0];
    assign CONV_W2_REN = ren_q[1];
    assign CONV_B1_REN = ren_q[2];
    assign CONV_B2_REN = ren_q[3];

    cnn_param_checksum #(.DW(DW)) u_wsum (
        .clk    (CLK),
        .rst    (RST),
        .clear  (start_ok),
        .acc_en (hs & ~ABORT),
        .data   (PARAM_DATA),
        .sum    (wsum)
    );

    cnn_param_checksum #(.DW(DW)) u_rsum (
        .clk    (CLK),
        .rst    (RST),
        .clear  (start_ok),
        .acc_en (|rv_q),
        .data   (rdata_sel),
        .sum    (rsum)
    );

endmodule

// File: tb/tb_cnn_layer2_param_loader.sv
// Scoreboard bench for cnn_layer2_param_loader: expected writes are queued as
// stream words are driven and popped as WEN pulses appear on the memory ports.
module tb_cnn_layer2_param_loader;

    localparam int DW    = 24;
    localparam int NW1   = 150;
    localparam int NW2   = 150;
    localparam int NB1   = 6;
    localparam int NB2   = 4;
    localparam int NALL  = NW1 + NW2 + NB1 + NB2;

    logic          CLK, RST, START, ABORT, SKIP_VERIFY, PARAM_VALID, PARAM_READY;
    logic [DW-1:0] PARAM_DATA;
    logic          W1_WEN, W1_REN, W2_WEN, W2_REN, B1_WEN, B1_REN, B2_WEN, B2_REN;
    logic [7:0]    W1_ADDR, W2_ADDR;
    logic [2:0]    B1_ADDR;
    logic [1:0]    B2_ADDR;
    logic [DW-1:0] W1_WDATA, W2_WDATA, B1_WDATA, B2_WDATA;
    logic [DW-1:0] W1_RDATA, W2_RDATA, B1_RDATA, B2_RDATA;
    logic          BUSY, DONE, ERR;

    logic [DW-1:0] m1 [256];
    logic [DW-1:0] m2 [256];
    logic [DW-1:0] mb1 [8];
    logic [DW-1:0] mb2 [4];
    bit            corrupt;

    typedef struct {int mem; int addr; int data;} exp_t;
    exp_t exp_q[$];

    int total, bad;
    int wen_cnt, ren_cnt, done_cnt, rd_idx;
    longint wr_sum;

    logic [4*DW+4+21+8-1:0] all_outs;
    assign all_outs = {BUSY, DONE, ERR, PARAM_READY,
                       W1_WEN, W1_REN, W2_WEN, W2_REN, B1_WEN, B1_REN, B2_WEN, B2_REN,
                       W1_ADDR, W2_ADDR, B1_ADDR, B2_ADDR,
                       W1_WDATA, W2_WDATA, B1_WDATA, B2_WDATA};

    cnn_layer2_param_loader #(.DW(DW), .N_W1(NW1), .N_W2(NW2), .N_B1(NB1), .N_B2(NB2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .SKIP_VERIFY(SKIP_VERIFY),
        .PARAM_VALID(PARAM_VALID), .PARAM_DATA(PARAM_DATA), .PARAM_READY(PARAM_READY),
        .CONV_W1_WEN(W1_WEN), .CONV_W1_REN(W1_REN), .CONV_W1_ADDR(W1_ADDR),
        .CONV_W1_WDATA(W1_WDATA), .CONV_W1_RDATA(W1_RDATA),
        .CONV_W2_WEN(W2_WEN), .CONV_W2_REN(W2_REN), .CONV_W2_ADDR(W2_ADDR),
        .CONV_W2_WDATA(W2_WDATA), .CONV_W2_RDATA(W2_RDATA),
        .CONV_B1_WEN(B1_WEN), .CONV_B1_REN(B1_REN), .CONV_B1_ADDR(B1_ADDR),
        .CONV_B1_WDATA(B1_WDATA), .CONV_B1_RDATA(B1_RDATA),
        .CONV_B2_WEN(B2_WEN), .CONV_B2_REN(B2_REN), .CONV_B2_ADDR(B2_ADDR),
        .CONV_B2_WDATA(B2_WDATA), .CONV_B2_RDATA(B2_RDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read memory model; optional fault returns zero for W2[7].
    always @(posedge CLK) begin
        if (W1_WEN) m1[W1_ADDR] <= W1_WDATA;
        if (W2_WEN) m2[W2_ADDR] <= W2_WDATA;
        if (B1_WEN) mb1[B1_ADDR] <= B1_WDATA;
        if (B2_WEN) mb2[B2_ADDR] <= B2_WDATA;
        if (W1_REN) W1_RDATA <= m1[W1_ADDR];
        if (W2_REN) W2_RDATA <= (corrupt && W2_ADDR == 8'd7) ? '0 : m2[W2_ADDR];
        if (B1_REN) B1_RDATA <= mb1[B1_ADDR];
        if (B2_REN) B2_RDATA <= mb2[B2_ADDR];
    end

    function automatic exp_t exp_of(input int i);
        exp_t e;
        e.data = i;
        if (i < NW1)                  begin e.mem = 0; e.addr = i; end
        else if (i < NW1 + NW2)       begin e.mem = 1; e.addr = i - NW1; end
        else if (i < NW1 + NW2 + NB1) begin e.mem = 2; e.addr = i - NW1 - NW2; end
        else                          begin e.mem = 3; e.addr = i - NW1 - NW2 - NB1; end
        return e;
    endfunction

    task automatic monitor();
        int   nen, om, oa, od;
        bit   seen;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b1) begin
                nen = int'(W1_WEN) + int'(W2_WEN) + int'(B1_WEN) + int'(B2_WEN) +
                      int'(W1_REN) + int'(W2_REN) + int'(B1_REN) + int'(B2_REN);
                if (nen > 0) begin
                    total++;
                    if (nen > 1) begin
                        bad++;
                        $display("[TB] FAIL one_hot_enable: got %0d enables, required at most 1", nen);
                    end
                end
                seen = 1'b1;
                if (W1_WEN)      begin om = 0; oa = int'(W1_ADDR); od = int'(W1_WDATA); end
                else if (W2_WEN) begin om = 1; oa = int'(W2_ADDR); od = int'(W2_WDATA); end
                else if (B1_WEN) begin om = 2; oa = int'(B1_ADDR); od = int'(B1_WDATA); end
                else if (B2_WEN) begin om = 3; oa = int'(B2_ADDR); od = int'(B2_WDATA); end
                else seen = 1'b0;
                if (seen) begin
                    wen_cnt++;
                    wr_sum += od;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_write: got mem=%0d addr=%0d data=%0d, required none", om, oa, od);
                    end else begin
                        e = exp_q.pop_front();
                        if (om !== e.mem || oa !== e.addr || od !== e.data) begin
                            bad++;
                            $display("[TB] FAIL write_seq: got mem=%0d addr=%0d data=%0d, required mem=%0d addr=%0d data=%0d",
                                     om, oa, od, e.mem, e.addr, e.data);
                        end
                    end
                end
                seen = 1'b1;
                if (W1_REN)      begin om = 0; oa = int'(W1_ADDR); end
                else if (W2_REN) begin om = 1; oa = int'(W2_ADDR); end
                else if (B1_REN) begin om = 2; oa = int'(B1_ADDR); end
                else if (B2_REN) begin om = 3; oa = int'(B2_ADDR); end
                else seen = 1'b0;
                if (seen) begin
                    e = exp_of(rd_idx);
                    rd_idx++;
                    ren_cnt++;
                    total++;
                    if (om !== e.mem || oa !== e.addr) begin
                        bad++;
                        $display("[TB] FAIL read_seq: got mem=%0d addr=%0d, required mem=%0d addr=%0d", om, oa, e.mem, e.addr);
                    end
                end
                if (DONE === 1'b1) done_cnt++;
            end
        end
    endtask

    task automatic clear_counts();
        wen_cnt = 0; ren_cnt = 0; done_cnt = 0; rd_idx = 0; wr_sum = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start(input bit skip);
        @(negedge CLK);
        START = 1'b1;
        SKIP_VERIFY = skip;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Presents words 0..n-1; abort_idx / start_idx inject ABORT or START with that word.
    task automatic drive_words(input int n, input bit gaps, input int abort_idx, input int start_idx);
        int w;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                PARAM_VALID = 1'b0;
                @(negedge CLK);
            end
            PARAM_VALID = 1'b1;
            PARAM_DATA  = DW'(i);
            if (i == abort_idx) ABORT = 1'b1;
            else exp_q.push_back(exp_of(i));
            if (i == start_idx) START = 1'b1;
            w = 0;
            while (PARAM_READY !== 1'b1 && w < 50) begin
                @(negedge CLK);
                w++;
            end
            if (w >= 50) begin
                total++; bad++;
                $display("[TB] FAIL ready_timeout: word %0d not accepted, required acceptance", i);
                PARAM_VALID = 1'b0;
                return;
            end
            @(negedge CLK);
            START = 1'b0;
            if (i == abort_idx) begin
                ABORT = 1'b0;
                PARAM_VALID = 1'b0;
                return;
            end
        end
        PARAM_VALID = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (DONE !== 1'b1 && c < 1000) begin
            @(negedge CLK);
            c++;
        end
        total++;
        if (DONE !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_done: got DONE=%b, required 1 within 1000 cycles", name, DONE);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", all_outs);
        end
        @(negedge CLK);
        RST = 1'b0;
        clear_counts();
        pulse_start(1'b0);
        drive_words(NW1 + 10, 1'b0, -1, -1);
        total++;
        if (BUSY !== 1'b1 || PARAM_READY !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_w2_busy: got BUSY=%b READY=%b, required 1 1", BUSY, PARAM_READY);
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset_outputs: got %h, required 0", all_outs);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (BUSY !== 1'b0 || wen_cnt !== NW1 + 10) begin
            bad++;
            $display("[TB] FAIL after_reset: got BUSY=%b wen=%0d, required 0 %0d", BUSY, wen_cnt, NW1 + 10);
        end
    endtask

    task automatic test_full_load(input bit bad_mem, input string name);
        clear_counts();
        corrupt = bad_mem;
        pulse_start(1'b0);
        total++;
        if (BUSY !== 1'b1 || ERR !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_start: got BUSY=%b ERR=%b, required 1 0", name, BUSY, ERR);
        end
        drive_words(NALL, 1'b0, -1, -1);
        wait_done(name);
        total++;
        if (ERR !== bad_mem) begin
            bad++;
            $display("[TB] FAIL %s_err: got %b, required %b", name, ERR, bad_mem);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (done_cnt !== 1 || wen_cnt !== NALL || ren_cnt !== NALL || exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL %s_counts: got done=%0d wen=%0d ren=%0d left=%0d, required 1 %0d %0d 0",
                     name, done_cnt, wen_cnt, ren_cnt, exp_q.size(), NALL, NALL);
        end
        total++;
        if (wr_sum !== 64'd47895 || BUSY !== 1'b0 || ERR !== bad_mem) begin
            bad++;
            $display("[TB] FAIL %s_sum: got sum=%0d BUSY=%b ERR=%b, required 47895 0 %b", name, wr_sum, BUSY, ERR, bad_mem);
        end
        corrupt = 1'b0;
    endtask

    task automatic test_start_ignored();
        clear_counts();
        pulse_start(1'b1);
        total++;
        if (ERR !== 1'b0) begin
            bad++;
            $display("[TB] FAIL start_clears_err: got %b, required 0", ERR);
        end
        drive_words(NALL, 1'b0, -1, NW1 + NW2 + 2);
        total++;
        if (DONE !== 1'b1) begin
            bad++;
            $display("[TB] FAIL skip_done_timing: got DONE=%b, required 1 after last B2 handshake", DONE);
        end
        @(negedge CLK);
        total++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL skip_done_pulse: got DONE=%b BUSY=%b, required 0 0", DONE, BUSY);
        end
        repeat (3) @(negedge CLK);
        total++;
        if (ren_cnt !== 0 || done_cnt !== 1 || wen_cnt !== NALL || exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL skip_counts: got ren=%0d done=%0d wen=%0d left=%0d, required 0 1 %0d 0",
                     ren_cnt, done_cnt, wen_cnt, exp_q.size(), NALL);
        end
    endtask

    task automatic test_gaps();
        clear_counts();
        pulse_start(1'b1);
        drive_words(NALL, 1'b1, -1, -1);
        wait_done("gaps");
        repeat (3) @(negedge CLK);
        total++;
        if (wen_cnt !== NALL || exp_q.size() !== 0 || done_cnt !== 1) begin
            bad++;
            $display("[TB] FAIL gaps_counts: got wen=%0d left=%0d done=%0d, required %0d 0 1",
                     wen_cnt, exp_q.size(), done_cnt, NALL);
        end
    endtask

    task automatic test_abort();
        clear_counts();
        pulse_start(1'b0);
        drive_words(NW1 + 21, 1'b0, NW1 + 20, -1);
        total++;
        if (BUSY !== 1'b0 || PARAM_READY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_idle: got BUSY=%b READY=%b, required 0 0", BUSY, PARAM_READY);
        end
        repeat (5) @(negedge CLK);
        total++;
        if (wen_cnt !== NW1 + 20 || done_cnt !== 0 || ERR !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_quiet: got wen=%0d done=%0d ERR=%b, required %0d 0 0",
                     wen_cnt, done_cnt, ERR, NW1 + 20);
        end
        START = 1'b1;
        ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_beats_start: got BUSY=%b, required 0", BUSY);
        end
        pulse_start(1'b0);
        drive_words(3, 1'b0, -1, -1);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        @(negedge CLK);
        total++;
        if (wen_cnt !== NW1 + 23 || exp_q.size() !== 0 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL restart_w1: got wen=%0d left=%0d BUSY=%b, required %0d 0 0",
                     wen_cnt, exp_q.size(), BUSY, NW1 + 23);
        end
    endtask

    initial begin
        total = 0; bad = 0; corrupt = 1'b0;
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; SKIP_VERIFY = 1'b0;
        PARAM_VALID = 1'b0; PARAM_DATA = '0;
        clear_counts();
        fork
            monitor();
        join_none
        test_reset();
        test_full_load(1'b0, "full");
        test_full_load(1'b1, "corrupt");
        test_start_ignored();
        test_gaps();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
